fp_mul_iter: RTL and testbench

//   Parametrised, iterative (shift-add) IEEE-754-style floating-point multiplier with valid/busy handshake.

---
 rtl/fp_mul_iter.sv | 237 +++++++++++++++++++++++
 tb/tb_fp_mul_iter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_iter.sv
// Iterative shift-add floating-point multiplier: one multiplier bit per cycle,
// then normalise and round, with valid/busy handshake and IEEE-style exception flags.
`timescale 1ns/1ps
module fp_mul_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [EXP_W+MAN_W:0] i_data_a,
    input  logic [EXP_W+MAN_W:0] i_data_b,
    input  logic                 i_rnd_mode,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [EXP_W+MAN_W:0] o_cal_result,
    output logic [3:0]           o_flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int M    = MAN_W + 1;
    localparam int PW   = 2 * M;
    localparam int XW   = EXP_W + 2;
    localparam int CW   = $clog2(M + 1);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [XW-1:0] EXP_OVF = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ONE = XW'(1);

    typedef enum logic [1:0] {IDLE, MUL, RND, DONE} state_t;

    state_t state_q, state_d;
    logic   accept;

    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] frac_a, frac_b;
    logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic             sign_in, special_in;
    logic [W-1:0]     special_res_in;
    logic [3:0]       special_flags_in;

    logic                 sign_q, rnd_mode_q, special_q, rnd_phase_q;
    logic [W-1:0]         special_res_q;
    logic [3:0]           special_flags_q;
    logic signed [XW-1:0] exp_q;
    logic [PW-1:0]        acc_q, mcand_q;
    logic [M-1:0]         mplier_q;
    logic [CW-1:0]        cnt_q;
    logic [M-1:0]         norm_man_q;
    logic                 guard_q, sticky_q;

    logic [M-1:0]         norm_man;
    logic                 norm_guard, norm_sticky;
    logic signed [XW-1:0] norm_exp;

    logic                 round_up;
    logic [M:0]           man_sum;
    logic signed [XW-1:0] rnd_exp;
    logic [MAN_W-1:0]     rnd_frac;
    logic [W-1:0]         result_d;
    logic [3:0]           flags_d;

    assign exp_a  = i_data_a[W-2 -: EXP_W];
    assign exp_b  = i_data_b[W-2 -: EXP_W];
    assign frac_a = i_data_a[MAN_W-1:0];
    assign frac_b = i_data_b[MAN_W-1:0];
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);
    assign inf_a  = (&exp_a) && (frac_a == '0);
    assign inf_b  = (&exp_b) && (frac_b == '0);
    assign nan_a  = (&exp_a) && (|frac_a);
    assign nan_b  = (&exp_b) && (|frac_b);
    assign sign_in = i_data_a[W-1] ^ i_data_b[W-1];

    // Special operand classes are resolved at accept and simply ride along the full latency.
    always_comb begin
        special_in       = 1'b0;
        special_res_in   = '0;
        special_flags_in = 4'b0000;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            special_in       = 1'b1;
            special_res_in   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            special_flags_in = 4'b1000;
        end else if (inf_a || inf_b) begin
            special_in     = 1'b1;
            special_res_in = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero_a || zero_b) begin
            special_in     = 1'b1;
            special_res_in = {sign_in, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    accept  = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (cnt_q == CW'(M - 1)) begin
                    state_d = RND;
                end
            end
            RND: begin
                if (rnd_phase_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (i_valid) begin
                    accept  = 1'b1;
                    state_d = MUL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy = (state_q == MUL) || (state_q == RND);

    // Product lies in [1,4); a set MSB means one extra binade.
    always_comb begin
        norm_man    = '0;
        norm_guard  = 1'b0;
        norm_sticky = 1'b0;
        norm_exp    = exp_q;
        if (acc_q[PW-1]) begin
            norm_man    = acc_q[PW-1 -: M];
            norm_guard  = acc_q[M-1];
            norm_sticky = |acc_q[M-2:0];
            norm_exp    = exp_q + XW'(1);
        end else begin
            norm_man    = acc_q[PW-2 -: M];
            norm_guard  = acc_q[M-2];
            norm_sticky = |acc_q[M-3:0];
        end
    end

    always_comb begin
        round_up = ~rnd_mode_q & guard_q & (sticky_q | norm_man_q[0]);
        man_sum  = {1'b0, norm_man_q} + {{M{1'b0}}, round_up};
        rnd_exp  = exp_q;
        rnd_frac = man_sum[MAN_W-1:0];
        if (man_sum[M]) begin
            rnd_exp  = exp_q + XW'(1);
            rnd_frac = man_sum[MAN_W:1];
        end
        result_d = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
        flags_d  = {3'b000, guard_q | sticky_q};
        if (special_q) begin
            result_d = special_res_q;
            flags_d  = special_flags_q;
        end else if (rnd_exp >= EXP_OVF) begin
            flags_d = 4'b0101;
            if (rnd_mode_q) begin
                result_d = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            end else begin
                result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
        end else if (rnd_exp < EXP_ONE) begin
            result_d = {sign_q, {(W-1){1'b0}}};
            flags_d  = 4'b0011;
        end
    end

    // RND spends one cycle normalising and a second applying the rounding decision.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sign_q          <= 1'b0;
            rnd_mode_q      <= 1'b0;
            special_q       <= 1'b0;
            special_res_q   <= '0;
            special_flags_q <= 4'b0000;
            exp_q           <= '0;
            acc_q           <= '0;
            mcand_q         <= '0;
            mplier_q        <= '0;
            cnt_q           <= '0;
            rnd_phase_q     <= 1'b0;
            norm_man_q      <= '0;
            guard_q         <= 1'b0;
            sticky_q        <= 1'b0;
            o_valid         <= 1'b0;
            o_cal_result    <= '0;
            o_flags         <= 4'b0000;
        end else begin
            o_valid <= 1'b0;
            if (accept) begin
                sign_q          <= sign_in;
                rnd_mode_q      <= i_rnd_mode;
                special_q       <= special_in;
                special_res_q   <= special_res_in;
                special_flags_q <= special_flags_in;
                exp_q           <= XW'(exp_a) + XW'(exp_b) - XW'(BIAS);
                acc_q           <= '0;
                mcand_q         <= PW'({1'b1, frac_a});
                mplier_q        <= {1'b1, frac_b};
                cnt_q           <= '0;
                rnd_phase_q     <= 1'b0;
            end else if (state_q == MUL) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CW'(1);
            end else if (state_q == RND) begin
                if (!rnd_phase_q) begin
                    norm_man_q  <= norm_man;
                    guard_q     <= norm_guard;
                    sticky_q    <= norm_sticky;
                    exp_q       <= norm_exp;
                    rnd_phase_q <= 1'b1;
                end else begin
                    o_cal_result <= result_d;
                    o_flags      <= flags_d;
                    o_valid      <= 1'b1;
                    rnd_phase_q  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_iter.sv
// Directed and random checks of fp_mul_iter (single precision) against a
// real-number-style rounding model, with a per-cycle scoreboard on the outputs.
`timescale 1ns/1ps
module tb_fp_mul_iter;

    localparam int LATENCY = 26;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic [31:0] i_data_a;
    logic [31:0] i_data_b;
    logic        i_rnd_mode;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_cal_result;
    logic [3:0]  o_flags;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    int          last_acc = 0;
    bit          active = 1'b0;
    logic [31:0] held_res = '0;
    logic [3:0]  held_flg = '0;

    fp_mul_iter dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_data_a     (i_data_a),
        .i_data_b     (i_data_b),
        .i_rnd_mode   (i_rnd_mode),
        .o_busy       (o_busy),
        .o_valid      (o_valid),
        .o_cal_result (o_cal_result),
        .o_flags      (o_flags)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Exact product, then round by comparing the discarded remainder with half an ulp.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic mode,
                                  output logic [31:0] res, output logic [3:0] flg);
        int     ea, eb, e, sh;
        longint fa, fb, prod, q, r, half;
        logic   s, za, zb, ia, ib, na, nb, inexact;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = longint'(a[22:0]);
        fb = longint'(b[22:0]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (fa == 0);
        ib = (eb == 255) && (fb == 0);
        na = (ea == 255) && (fa != 0);
        nb = (eb == 255) && (fb != 0);
        if (na || nb || (ia && zb) || (ib && za)) begin
            res = 32'h7FC00000;
            flg = 4'b1000;
            return;
        end
        if (ia || ib) begin
            res = {s, 8'hFF, 23'h0};
            flg = 4'b0000;
            return;
        end
        if (za || zb) begin
            res = {s, 31'h0};
            flg = 4'b0000;
            return;
        end
        prod = ((longint'(1) << 23) + fa) * ((longint'(1) << 23) + fb);
        e = ea + eb - 127;
        if (prod >= (longint'(1) << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        q    = prod >> sh;
        r    = prod - (q << sh);
        half = longint'(1) << (sh - 1);
        inexact = (r != 0);
        if (!mode && ((r > half) || ((r == half) && ((q % 2) == 1)))) begin
            q = q + 1;
        end
        if (q == (longint'(1) << 24)) begin
            q = longint'(1) << 23;
            e = e + 1;
        end
        if (e >= 255) begin
            res = mode ? {s, 8'hFE, 23'h7FFFFF} : {s, 8'hFF, 23'h0};
            flg = 4'b0101;
        end else if (e <= 0) begin
            res = {s, 31'h0};
            flg = 4'b0011;
        end else begin
            res = {s, 8'(e), 23'(q)};
            flg = {3'b000, inexact};
        end
    endfunction

    always @(posedge i_clk) begin
        exp_t        ent;
        logic [31:0] r;
        logic [3:0]  f;
        cyc++;
        if (!i_rst_n) begin
            sb_q.delete();
            active = 1'b0;
        end else if (i_valid && (!active || cyc >= last_acc + LATENCY + 1)) begin
            model(i_data_a, i_data_b, i_rnd_mode, r, f);
            ent.res = r;
            ent.flg = f;
            ent.acc = cyc;
            sb_q.push_back(ent);
            last_acc = cyc;
            active   = 1'b1;
        end
    end

    always @(negedge i_clk) begin
        exp_t ent;
        logic model_busy;
        if (!i_rst_n) begin
            held_res = '0;
            held_flg = '0;
        end else begin
            model_busy = active && ((cyc - last_acc) < LATENCY);
            checkOutput("busy", {31'b0, o_busy}, {31'b0, model_busy});
            if (o_valid) begin
                if (sb_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_valid: o_valid=1 with result %h, required no result (cycle %0d)",
                             o_cal_result, cyc);
                end else begin
                    ent = sb_q.pop_front();
                    checkOutput("result", o_cal_result, ent.res);
                    checkOutput("flags", {28'b0, o_flags}, {28'b0, ent.flg});
                    checkOutput("latency", 32'(cyc - ent.acc), 32'(LATENCY));
                    held_res = ent.res;
                    held_flg = ent.flg;
                end
            end else begin
                checkOutput("hold_result", o_cal_result, held_res);
                checkOutput("hold_flags", {28'b0, o_flags}, {28'b0, held_flg});
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic mode);
        i_data_a   = a;
        i_data_b   = b;
        i_rnd_mode = mode;
        i_valid    = 1'b1;
        @(negedge i_clk);
        i_valid    = 1'b0;
    endtask

    task automatic waitValid(input string name, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if (o_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s_timeout: o_valid=0 after 40 cycles, required 1", name);
        end
    endtask

    task automatic expectResult(input string name, input logic [31:0] res, input logic [3:0] flg);
        bit seen;
        waitValid(name, seen);
        if (seen) begin
            checkOutput({name, "_res"}, o_cal_result, res);
            checkOutput({name, "_flags"}, {28'b0, o_flags}, {28'b0, flg});
        end
    endtask

    task automatic pinModel(input string name, input logic [31:0] a, input logic [31:0] b, input logic mode,
                            input logic [31:0] res, input logic [3:0] flg);
        logic [31:0] r;
        logic [3:0]  f;
        model(a, b, mode, r, f);
        checkOutput({name, "_model_res"}, r, res);
        checkOutput({name, "_model_flags"}, {28'b0, f}, {28'b0, flg});
    endtask

    function automatic logic [31:0] randOperand();
        int         k;
        logic [7:0] e;
        k = $urandom_range(0, 15);
        if (k == 0)      e = 8'h00;
        else if (k == 1) e = 8'hFF;
        else if (k == 2) e = 8'($urandom_range(0, 255));
        else             e = 8'($urandom_range(64, 190));
        if (k == 1 && $urandom_range(0, 1) == 0) begin
            return {1'($urandom), e, 23'h0};
        end
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    initial begin
        bit seen;
        i_rst_n    = 1'b0;
        i_valid    = 1'b0;
        i_data_a   = '0;
        i_data_b   = '0;
        i_rnd_mode = 1'b0;
        #1;
        checkOutput("reset_busy", {31'b0, o_busy}, 32'd0);
        checkOutput("reset_valid", {31'b0, o_valid}, 32'd0);
        checkOutput("reset_result", o_cal_result, 32'd0);
        checkOutput("reset_flags", {28'b0, o_flags}, 32'd0);
        repeat (2) @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        @(negedge i_clk);

        pinModel("p1", 32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
        pinModel("p2", 32'h3F800800, 32'h3F800800, 1'b0, 32'h3F801000, 4'b0001);
        pinModel("p3", 32'h7F000000, 32'h7F000000, 1'b1, 32'h7F7FFFFF, 4'b0101);
        pinModel("p4", 32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 4'b0011);
        pinModel("p5", 32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, 32'h407FFFFE, 4'b0001);

        applyStimulus(32'h3FC00000, 32'h40000000, 1'b0);
        expectResult("t1", 32'h40400000, 4'b0000);
        applyStimulus(32'hBFC00000, 32'h40000000, 1'b0);
        expectResult("t2_neg", 32'hC0400000, 4'b0000);
        applyStimulus(32'h3F800800, 32'h3F800800, 1'b0);
        expectResult("t2_tie", 32'h3F801000, 4'b0001);
        applyStimulus(32'h7F000000, 32'h7F000000, 1'b0);
        expectResult("t3_ovf_rne", 32'h7F800000, 4'b0101);
        applyStimulus(32'h7F000000, 32'h7F000000, 1'b1);
        expectResult("t3_ovf_trunc", 32'h7F7FFFFF, 4'b0101);
        applyStimulus(32'h7F800000, 32'h00000000, 1'b0);
        expectResult("t4_inf_zero", 32'h7FC00000, 4'b1000);
        applyStimulus(32'h00800000, 32'h3F000000, 1'b0);
        expectResult("t4_unf", 32'h00000000, 4'b0011);
        applyStimulus(32'h3F800001, 32'h3F800001, 1'b1);
        expectResult("t4_trunc", 32'h3F800002, 4'b0001);
        applyStimulus(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0);
        expectResult("t4_carry", 32'h407FFFFE, 4'b0001);

        applyStimulus(32'h3FC00000, 32'h3FC00000, 1'b0);
        repeat (4) @(negedge i_clk);
        applyStimulus(32'h40000000, 32'h40000000, 1'b0);
        expectResult("t5_first", 32'h40100000, 4'b0000);
        applyStimulus(32'h40000000, 32'h40000000, 1'b0);
        expectResult("t5_b2b", 32'h40800000, 4'b0000);
        repeat (30) @(negedge i_clk);

        applyStimulus(32'h3FC00000, 32'h40000000, 1'b0);
        repeat (8) @(negedge i_clk);
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'b0, o_busy}, 32'd0);
        checkOutput("abort_valid", {31'b0, o_valid}, 32'd0);
        checkOutput("abort_result", o_cal_result, 32'd0);
        checkOutput("abort_flags", {28'b0, o_flags}, 32'd0);
        repeat (2) @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        repeat (30) @(negedge i_clk);
        applyStimulus(32'hBFC00000, 32'h3FC00000, 1'b0);
        expectResult("t6_after", 32'hC0100000, 4'b0000);

        for (int n = 0; n < 300; n++) begin
            applyStimulus(randOperand(), randOperand(), 1'($urandom_range(0, 1)));
            waitValid("random", seen);
        end

        repeat (5) @(negedge i_clk);
        checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at 1ms, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
